// File: rtl/multicycle_ctrl.sv
// Moore sequencing controller for the multi-cycle MIPS-subset datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback over a shared memory port.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_source,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             illegal_op,
   output logic             halted,
   output logic [CNT_W-1:0] instr_retired
);

   typedef enum logic [3:0] {
      StReset, StFetch, StDecode, StExR, StExAddr, StExOri, StExBeq, StExJ,
      StMemRd, StMemWr, StWbR, StWbI, StWbLw, StHaltErr
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [3:0] WaitLimit = 4'(TIMEOUT);

   state_e           state_q, state_d;
   logic [3:0]       wait_q, wait_d;
   logic [CNT_W-1:0] retired_q;
   logic             retire;

   // Branch decision is made in the datapath via pc_write_cond; the flag is not needed here.
   logic unused_zero;
   assign unused_zero = zero;

   assign instr_retired = retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StReset;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_d        = '0;
      retire        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
      halted        = 1'b0;

      unique case (state_q)
         StReset: state_d = StFetch;
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (wait_q == WaitLimit) begin
               state_d = StHaltErr;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         StDecode: begin
            alu_src_b = 2'b11;
            case (opcode)
               OpRtype:          state_d = StExR;
               OpLw, OpSw, OpAddi: state_d = StExAddr;
               OpOri:            state_d = StExOri;
               OpBeq:            state_d = StExBeq;
               OpJ:              state_d = StExJ;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = StFetch;
               end
            endcase
         end
         StExR: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
            state_d   = StWbR;
         end
         StExAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            // IR still holds the opcode, so the memory/immediate split is resolved here.
            if (opcode == OpLw)      state_d = StMemRd;
            else if (opcode == OpSw) state_d = StMemWr;
            else                     state_d = StWbI;
         end
         StExOri: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 3'b011;
            state_d   = StWbI;
         end
         StExBeq: begin
            alu_src_a     = 1'b1;
            alu_op        = 3'b001;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            retire        = 1'b1;
            state_d       = StFetch;
         end
         StExJ: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            retire    = 1'b1;
            state_d   = StFetch;
         end
         StMemRd, StMemWr: begin
            mem_read  = (state_q == StMemRd);
            mem_write = (state_q == StMemWr);
            iord      = 1'b1;
            if (mem_ready) begin
               if (state_q == StMemRd) begin
                  state_d = StWbLw;
               end else begin
                  retire  = 1'b1;
                  state_d = StFetch;
               end
            end else if (wait_q == WaitLimit) begin
               state_d = StHaltErr;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         StWbR, StWbI, StWbLw: begin
            reg_write  = 1'b1;
            reg_dst    = (state_q == StWbR);
            mem_to_reg = (state_q == StWbLw);
            retire     = 1'b1;
            state_d    = StFetch;
         end
         StHaltErr: halted = 1'b1;
         default:   state_d = StReset;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: phase/instruction-class reference model checked every cycle,
// plus directed literal checks pinning the walkthrough scenarios.
module tb_multicycle_ctrl;

   localparam int unsigned TIMEOUT = 15;
   localparam int unsigned CNT_W   = 32;

   localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000;
   localparam logic [5:0] ORI = 6'b001101, BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

   logic             clk, rst_n, zero, mem_ready;
   logic [5:0]       opcode;
   logic             mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
   logic [1:0]       pc_source, alu_src_b;
   logic             alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, halted;
   logic [2:0]       alu_op;
   logic [CNT_W-1:0] instr_retired;
   logic [18:0]      dut_ctrl;

   multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op),
      .halted(halted), .instr_retired(instr_retired)
   );

   assign dut_ctrl = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                      alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                      illegal_op, halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {PRst, PFetch, PDec, PEx, PMem, PWb, PHalt} phase_e;
   typedef enum {CR, CLw, CSw, CAddi, COri, CBeq, CJ, CIll} cls_e;

   function automatic cls_e classify(input logic [5:0] op);
      case (op)
         R_OP:    return CR;
         LW:      return CLw;
         SW:      return CSw;
         ADDI:    return CAddi;
         ORI:     return COri;
         BEQ:     return CBeq;
         JMP:     return CJ;
         default: return CIll;
      endcase
   endfunction

   function automatic logic [18:0] expect_ctrl(input phase_e p, input cls_e c, input logic rdy,
                                               input logic [5:0] op);
      logic mr, mw, io, irw, pw, pwc, sa, rd, m2r, rw, ill, h;
      logic [1:0] ps, sb;
      logic [2:0] ao;
      {mr, mw, io, irw, pw, pwc, sa, rd, m2r, rw, ill, h} = '0;
      ps = 2'b00; sb = 2'b00; ao = 3'b000;
      case (p)
         PFetch: begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
         PDec:   begin sb = 2'b11; ill = (classify(op) == CIll); end
         PEx: case (c)
            CR:             begin sa = 1; ao = 3'b010; end
            CLw, CSw, CAddi: begin sa = 1; sb = 2'b10; end
            COri:           begin sa = 1; sb = 2'b10; ao = 3'b011; end
            CBeq:           begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; end
            CJ:             begin pw = 1; ps = 2'b10; end
            default: ;
         endcase
         PMem:   begin io = 1; mr = (c == CLw); mw = (c == CSw); end
         PWb:    begin rw = 1; rd = (c == CR); m2r = (c == CLw); end
         PHalt:  h = 1;
         default: ;
      endcase
      return {mr, mw, io, irw, pw, pwc, ps, sa, sb, ao, rd, m2r, rw, ill, h};
   endfunction

   initial begin
      phase_e           m_phase;
      cls_e             m_cls;
      int               m_wait;
      logic [CNT_W-1:0] m_ret;
      m_phase = PRst; m_cls = CR; m_wait = 0; m_ret = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_phase = PRst; m_wait = 0; m_ret = '0;
         end
         check("ctrl", 32'(dut_ctrl), 32'(expect_ctrl(m_phase, m_cls, mem_ready, opcode)));
         check("retired", instr_retired, m_ret);
         if (rst_n) begin
            case (m_phase)
               PRst: m_phase = PFetch;
               PDec: begin
                  m_cls   = classify(opcode);
                  m_phase = (m_cls == CIll) ? PFetch : PEx;
               end
               PEx: begin
                  if (m_cls == CBeq || m_cls == CJ) begin m_ret++; m_phase = PFetch; end
                  else if (m_cls == CLw || m_cls == CSw) m_phase = PMem;
                  else m_phase = PWb;
               end
               PFetch, PMem: begin
                  if (mem_ready) begin
                     m_wait = 0;
                     if (m_phase == PFetch) m_phase = PDec;
                     else if (m_cls == CLw) m_phase = PWb;
                     else begin m_ret++; m_phase = PFetch; end
                  end else if (m_wait == int'(TIMEOUT)) begin
                     m_wait = 0; m_phase = PHalt;
                  end else begin
                     m_wait++;
                  end
               end
               PWb: begin m_ret++; m_phase = PFetch; end
               default: ;
            endcase
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input logic rdy, input logic [5:0] op);
      @(posedge clk);
      #1;
      mem_ready = rdy;
      opcode    = op;
      @(negedge clk);
   endtask

   initial begin
      int rd_cycles;
      int halt_at;
      rst_n = 1'b0; mem_ready = 1'b0; opcode = R_OP; zero = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_outputs", 32'(dut_ctrl), 32'd0);
      check("reset_retired", instr_retired, 32'd0);

      // R-type, zero-wait memory
      step(1, R_OP);
      check("r_fetch_irw", 32'(ir_write), 32'd1);
      check("r_fetch_srcb", 32'(alu_src_b), 32'd1);
      step(1, R_OP);
      check("r_dec_srcb", 32'(alu_src_b), 32'd3);
      step(1, R_OP);
      check("r_ex_aluop", 32'(alu_op), 32'd2);
      step(1, R_OP);
      check("r_wb_regw", 32'({reg_write, reg_dst}), 32'd3);

      // lw with three wait cycles in MEM_RD
      step(1, LW);
      check("r_retired", instr_retired, 32'd1);
      step(1, LW);
      step(1, LW);
      rd_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         step(i == 3, LW);
         if (mem_read && iord) rd_cycles++;
      end
      check("lw_mem_hold", 32'(rd_cycles), 32'd4);
      step(1, LW);
      check("lw_wb_m2r", 32'({reg_write, mem_to_reg}), 32'd3);

      // beq then j
      zero = 1'b1;
      step(1, BEQ);
      check("lw_retired", instr_retired, 32'd2);
      step(1, BEQ);
      step(1, BEQ);
      check("beq_ex", 32'({pc_write_cond, pc_source}), 32'b101);
      step(1, JMP);
      step(1, JMP);
      step(1, JMP);
      check("j_ex", 32'({pc_write, pc_source}), 32'b110);

      // illegal opcode
      step(1, BAD);
      check("bj_retired", instr_retired, 32'd4);
      step(1, BAD);
      check("ill_pulse", 32'(illegal_op), 32'd1);
      step(1, ADDI);
      check("ill_back_fetch", 32'({illegal_op, mem_read}), 32'd1);
      check("ill_retired", instr_retired, 32'd4);
      step(1, ADDI);
      step(1, ADDI);
      check("addi_ex_srcb", 32'(alu_src_b), 32'd2);
      step(1, ADDI);
      check("addi_wb", 32'({reg_write, reg_dst}), 32'd2);
      step(1, ORI);
      step(1, ORI);
      step(1, ORI);
      check("ori_ex_aluop", 32'(alu_op), 32'd3);
      step(1, ORI);

      // sw: ready arrives exactly when the wait counter equals TIMEOUT
      step(1, SW);
      check("ori_retired", instr_retired, 32'd6);
      step(1, SW);
      step(1, SW);
      for (int i = 0; i < int'(TIMEOUT); i++) step(0, SW);
      step(1, SW);
      check("sw_ready_wins", 32'({mem_write, halted}), 32'd2);
      step(1, R_OP);
      check("sw_retired", instr_retired, 32'd7);
      step(1, R_OP);
      step(1, R_OP);
      step(1, R_OP);

      // fetch timeout into HALT_ERR
      halt_at = 0;
      for (int i = 0; i < 20; i++) begin
         step(0, R_OP);
         if (halted && halt_at == 0) halt_at = i + 1;
      end
      check("halt_cycle", 32'(halt_at), 32'd17);
      for (int i = 0; i < 3; i++) step(1, R_OP);
      check("halt_sticky", 32'({halted, mem_read}), 32'd2);
      check("halt_retired", instr_retired, 32'd8);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("halt_reset", 32'(halted), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rerun_reset_state", 32'(dut_ctrl), 32'd0);
      step(1, R_OP);
      check("rerun_fetch", 32'(mem_read), 32'd1);
      step(1, R_OP);
      step(1, R_OP);
      step(1, R_OP);

      // async reset during MEM_WR
      step(1, SW);
      check("pre_sw_retired", instr_retired, 32'd1);
      step(1, SW);
      step(1, SW);
      step(0, SW);
      check("sw_mem_write", 32'(mem_write), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_mem_write", 32'({mem_write, reg_write}), 32'd0);
      check("async_retired", instr_retired, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      step(1, R_OP);
      check("post_reset_fetch", 32'({mem_read, ir_write}), 32'd3);
      step(1, R_OP);
      step(1, R_OP);
      step(1, R_OP);
      step(1, R_OP);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style sequencing controller for a multi-cycle MIPS-subset datapath built from the existing ALU, ALU_Control, Register, Data_Memory, sign-extend and 2:1 mux blocks.
- Replaces the combinational single-cycle Control decoder.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath enables and mux selects.
- Handshakes with a shared instruction/data memory port that may take several cycles.

Parameters:
TIMEOUT, 15, max cycles to wait for mem_ready before entering HALT_ERR (4-bit wait counter; legal range 1..15)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
mem_read  output  1  memory read request
mem_write  output  1  memory write request
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  output  1  load instruction register
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alu_src_a  output  1  0 = PC, 1 = rs data
alu_src_b  output  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_op  output  3  to ALU_Control: 000 add, 001 sub, 010 funct, 011 or
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  0 = ALUOut, 1 = MDR
reg_write  output  1  register file write enable
illegal_op  output  1  one-cycle pulse on unsupported opcode
halted  output  1  high in HALT_ERR
instr_retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset (rst_n = 0, async):
  - State goes to RESET; instr_retired = 0; wait counter = 0.
  - Every output is 0 while in RESET.
  - RESET always advances to FETCH on the first clock after rst_n rises.
- Outputs decode from the state register only, so they are glitch-free Moore outputs. Any signal not listed for a state is 0.
- FETCH:
  - mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 000.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, pc_source = 00; next state DECODE.
  - ir_write and pc_write are the only outputs that also depend on mem_ready.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = 000 (precompute branch target).
  - Dispatch on opcode:
    - 000000 -> EX_R
    - 100011 (lw), 101011 (sw), 001000 (addi) -> EX_ADDR
    - 001101 (ori) -> EX_ORI
    - 000100 (beq) -> EX_BEQ
    - 000010 (j) -> EX_J
    - anything else -> pulse illegal_op, go to FETCH; instr_retired unchanged.
- EX_R: alu_src_a = 1, alu_src_b = 00, alu_op = 010 -> WB_R.
- EX_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 000. Next state: lw -> MEM_RD, sw -> MEM_WR, addi -> WB_I.
- EX_ORI: alu_src_a = 1, alu_src_b = 10, alu_op = 011 -> WB_I.
- EX_BEQ: alu_src_a = 1, alu_src_b = 00, alu_op = 001, pc_write_cond = 1, pc_source = 01 -> FETCH; retires.
- EX_J: pc_write = 1, pc_source = 10 -> FETCH; retires.
- MEM_RD: mem_read = 1, iord = 1. On mem_ready -> WB_LW.
- MEM_WR: mem_write = 1, iord = 1. On mem_ready -> FETCH; retires.
- WB_R: reg_write = 1, reg_dst = 1, mem_to_reg = 0 -> FETCH; retires.
- WB_I: reg_write = 1, reg_dst = 0, mem_to_reg = 0 -> FETCH; retires.
- WB_LW: reg_write = 1, reg_dst = 0, mem_to_reg = 1 -> FETCH; retires.
- Retire: instr_retired increments by 1 on the clock edge leaving a retiring state. It wraps modulo 2^CNT_W with no saturation.
- Memory wait:
  - In FETCH, MEM_RD and MEM_WR, request signals stay asserted every cycle while mem_ready = 0.
  - The wait counter increments each such cycle and clears on state exit.
  - If the counter reaches TIMEOUT with mem_ready still 0 -> HALT_ERR.
  - mem_ready sampled high in the same cycle the counter equals TIMEOUT completes normally: ready wins.
- HALT_ERR: all outputs 0 except halted = 1. Only reset leaves this state.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-instruction aborts immediately with no partial reg_write or mem_write. After release, execution restarts at FETCH.
- Latency with zero-wait memory (mem_ready tied high): lw 5 cycles; R/sw/addi/ori 4; beq/j 3.

Test Plan:
- Reset, then mem_ready tied 1, opcode 000000 -> states FETCH, DECODE, EX_R, WB_R; reg_write = 1 with reg_dst = 1 in cycle 4; instr_retired = 1.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD -> mem_read and iord held high for 4 cycles, then WB_LW with mem_to_reg = 1; total 8 cycles.
- beq (000100) with zero = 1, then j (000010) -> pc_write_cond = 1 and pc_source = 01 in cycle 3; pc_source = 10 with pc_write = 1 in cycle 3 of the jump; instr_retired = 2.
- Opcode 111111 -> illegal_op high for exactly 1 cycle in DECODE, next state FETCH, instr_retired unchanged.
- mem_ready held 0 in FETCH -> halted = 1 after 15 wait cycles; mem_ready = 1 then has no effect; rst_n pulse returns to RESET, then FETCH.
- Assert rst_n = 0 asynchronously during MEM_WR -> mem_write drops before the next edge, instr_retired = 0.
